dll_dlcmsm_fc: RTL and testbench
================================

DLL_DLCMSM_FC -- requirements
Module: dll_dlcmsm_fc

Interface
REQ-001 Parameter HDR_FC_W, default 8, header credit field width.
REQ-002 Parameter DATA_FC_W, default 12, data credit field width.
REQ-003 Parameter ADV_HDR, default 32, header credits advertised for each of P/NP/CPL.
REQ-004 Parameter ADV_DATA, default 256, data credits advertised for each of P/NP/CPL.
REQ-005 Parameter RESEND_CYC, default 34, cycles between successive InitFC DLLP requests (min 4).
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 rst  in  1  reset, asynchronous assert, active-high.
REQ-008 link_up_i  in  1  physical layer reports link up.
REQ-009 dllp_rx_valid_i  in  1  received DLLP valid this cycle.
REQ-010 dllp_rx_type_i  in  8  received DLLP type byte.
REQ-011 dllp_rx_hdr_fc_i  in  HDR_FC_W  received header credit field.
REQ-012 dllp_rx_data_fc_i  in  DATA_FC_W  received data credit field.
REQ-013 dllp_tx_valid_o  out  1  DLLP transmit request.
REQ-014 dllp_tx_ready_i  in  1  DLLP transmitter accepts request.
REQ-015 dllp_tx_type_o  out  8  type byte of requested DLLP.
REQ-016 dllp_tx_hdr_fc_o / dllp_tx_data_fc_o  out  HDR_FC_W / DATA_FC_W  advertised credits (ADV_HDR / ADV_DATA).
REQ-017 state_o  out  2  00 INACTIVE, 01 INIT1, 10 INIT2, 11 ACTIVE.
REQ-018 dl_up_o  out  1  high only in ACTIVE.
REQ-019 fc_hdr_lim_o / fc_data_lim_o  out  3*HDR_FC_W / 3*DATA_FC_W  partner credit limits; slice 0=P, 1=NP, 2=CPL.

Function
REQ-020 Type decode: InitFC1 P/NP/CPL = 0x40/0x50/0x60; InitFC2 = 0xC0/0xD0/0xE0; UpdateFC = 0x80/0x90/0xA0; upper nibble only compared, lower nibble (VC ID) ignored; other types ignored.
REQ-021 INACTIVE -> INIT1 on cycle after link_up_i sampled high.
REQ-022 Any state -> INACTIVE on cycle after link_up_i sampled low; clears FI1 flags, FI2 flag, credit limits, resend timer, dllp_tx_valid_o.
REQ-023 INIT1: requests InitFC1 P, NP, CPL in order, repeating; next request issued RESEND_CYC cycles after previous acceptance; timer counts from acceptance cycle.
REQ-024 INIT1: InitFC1 or InitFC2 of a type sets that type's FI1 flag and loads that type's hdr/data limit from rx fields; repeat receipt reloads limit.
REQ-025 INIT1 -> INIT2 on cycle after all three FI1 flags set AND the current CPL InitFC1 request has been accepted (full P/NP/CPL set sent at least once).
REQ-026 INIT2: same round-robin/timer as INIT1 using InitFC2 types, restarting at P.
REQ-027 INIT2: receipt of any InitFC2 or UpdateFC sets FI2; INIT2 -> ACTIVE on cycle after FI2 set; outstanding tx request dropped on entry to ACTIVE.
REQ-028 INIT2/ACTIVE: InitFC1/InitFC2 received do not change limits.
REQ-029 ACTIVE: UpdateFC of a type reloads that type's limits; dllp_tx_valid_o low.
REQ-030 Handshake: dllp_tx_valid_o and type/fc outputs held stable until cycle with dllp_tx_ready_i high; transfer on valid&ready.
REQ-031 Simultaneous rx and tx acceptance in same cycle both take effect.
REQ-032 link_up_i low and valid DLLP same cycle: link-down wins, DLLP discarded.

Reset
REQ-033 rst high: state INACTIVE, dl_up_o 0, dllp_tx_valid_o 0, tx type/fc outputs 0, all limits 0, flags 0, timer 0, immediately and asynchronously.
REQ-034 rst deasserted mid-operation restarts from INACTIVE; no state retained.

Verification
REQ-035 link_up 1, tx_ready always 1, no rx -> InitFC1 0x40, 0x50, 0x60, 0x40... at 34-cycle spacing, state stays 01.
REQ-036 INIT1, rx 0x40/0x50/0x60 with hdr 10/20/30 data 100/200/300 -> fc_hdr_lim_o = {30,20,10}, state 10 after CPL accepted, tx types 0xC0, 0xD0, 0xE0.
REQ-037 INIT2, rx 0x80 hdr 5 -> state 11, dl_up_o 1, tx_valid 0; then rx 0x90 hdr 7 data 9 -> NP slice = 7/9.
REQ-038 tx_ready held 0 for 50 cycles in INIT1 -> tx_valid stays 1, type 0x40 unchanged; no second request issued.
REQ-039 ACTIVE, link_up 0 -> next cycle state 00, dl_up_o 0, limits 0; link_up 1 -> INIT1, new InitFC1 0x40.
REQ-040 rst asserted mid-INIT2 -> outputs zero without clock edge; after release with link_up 1 -> INIT1 one cycle later.

Source files
------------

// File: rtl/dll_dlcmsm_fc.sv
// dll_dlcmsm_fc: data link control state machine with flow-control initialisation.
// Walks INACTIVE -> INIT1 -> INIT2 -> ACTIVE. It requests InitFC1/InitFC2 DLLPs
// round-robin (P, NP, CPL), captures the partner's credit limits, and raises
// dl_up_o once flow-control init completes. Later UpdateFC DLLPs refresh the limits.
module dll_dlcmsm_fc #(
  parameter int HDR_FC_W   = 8,
  parameter int DATA_FC_W  = 12,
  parameter int ADV_HDR    = 32,
  parameter int ADV_DATA   = 256,
  parameter int RESEND_CYC = 34
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   link_up_i,
  input  logic                   dllp_rx_valid_i,
  input  logic [7:0]             dllp_rx_type_i,
  input  logic [HDR_FC_W-1:0]    dllp_rx_hdr_fc_i,
  input  logic [DATA_FC_W-1:0]   dllp_rx_data_fc_i,
  output logic                   dllp_tx_valid_o,
  input  logic                   dllp_tx_ready_i,
  output logic [7:0]             dllp_tx_type_o,
  output logic [HDR_FC_W-1:0]    dllp_tx_hdr_fc_o,
  output logic [DATA_FC_W-1:0]   dllp_tx_data_fc_o,
  output logic [1:0]             state_o,
  output logic                   dl_up_o,
  output logic [3*HDR_FC_W-1:0]  fc_hdr_lim_o,
  output logic [3*DATA_FC_W-1:0] fc_data_lim_o
);

  localparam int TMR_W = $clog2(RESEND_CYC + 1);

  typedef enum logic [1:0] {
    ST_INACTIVE = 2'b00,
    ST_INIT1    = 2'b01,
    ST_INIT2    = 2'b10,
    ST_ACTIVE   = 2'b11
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       fi1;
  logic             fi2;
  logic             cpl_sent;
  logic [1:0]       tx_idx;
  logic [TMR_W-1:0] timer;
  logic             rx_fc1, rx_fc2, rx_upd;
  logic [1:0]       rx_sel;
  logic [2:0]       fi1_hit;
  logic             tx_accept;
  logic [1:0]       cls_entry, cls_cur;

  // Bits 5:4 of every recognised type select P/NP/CPL; the VC nibble is ignored.
  assign rx_sel    = dllp_rx_type_i[5:4];
  assign tx_accept = dllp_tx_valid_o && dllp_tx_ready_i;
  assign fi1_hit   = (state == ST_INIT1 && (rx_fc1 || rx_fc2)) ? (3'b001 << rx_sel) : 3'b000;
  assign cls_entry = (state_nxt == ST_INIT2) ? 2'b11 : 2'b01;
  assign cls_cur   = (state == ST_INIT2) ? 2'b11 : 2'b01;
  assign state_o   = state;
  assign dl_up_o   = (state == ST_ACTIVE);

  // Classify the received DLLP; a DLLP arriving while the link drops is discarded.
  always_comb begin
    rx_fc1 = 1'b0;
    rx_fc2 = 1'b0;
    rx_upd = 1'b0;
    if (dllp_rx_valid_i && link_up_i) begin
      casez (dllp_rx_type_i)
        8'b0100_????, 8'b0101_????, 8'b0110_????: rx_fc1 = 1'b1;
        8'b1100_????, 8'b1101_????, 8'b1110_????: rx_fc2 = 1'b1;
        8'b1000_????, 8'b1001_????, 8'b1010_????: rx_upd = 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state logic; INIT1 exits once all FI1 flags are set and a CPL request has gone out.
  always_comb begin
    state_nxt = state;
    if (!link_up_i) begin
      state_nxt = ST_INACTIVE;
    end else begin
      case (state)
        ST_INACTIVE: state_nxt = ST_INIT1;
        ST_INIT1: begin
          if (((fi1 | fi1_hit) == 3'b111) &&
              (cpl_sent || (tx_accept && tx_idx == 2'd2)))
            state_nxt = ST_INIT2;
        end
        ST_INIT2: begin
          if (fi2 || rx_fc2 || rx_upd)
            state_nxt = ST_ACTIVE;
        end
        ST_ACTIVE: state_nxt = ST_ACTIVE;
        default:   state_nxt = ST_INACTIVE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INACTIVE;
    else     state <= state_nxt;
  end

  // Flags, credit limits, and the InitFC request generator with its resend timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fi1               <= '0;
      fi2               <= 1'b0;
      cpl_sent          <= 1'b0;
      tx_idx            <= '0;
      timer             <= '0;
      dllp_tx_valid_o   <= 1'b0;
      dllp_tx_type_o    <= '0;
      dllp_tx_hdr_fc_o  <= '0;
      dllp_tx_data_fc_o <= '0;
      fc_hdr_lim_o      <= '0;
      fc_data_lim_o     <= '0;
    end else if (state_nxt == ST_INACTIVE) begin
      fi1               <= '0;
      fi2               <= 1'b0;
      cpl_sent          <= 1'b0;
      tx_idx            <= '0;
      timer             <= '0;
      dllp_tx_valid_o   <= 1'b0;
      dllp_tx_type_o    <= '0;
      dllp_tx_hdr_fc_o  <= '0;
      dllp_tx_data_fc_o <= '0;
      fc_hdr_lim_o      <= '0;
      fc_data_lim_o     <= '0;
    end else begin
      if (state == ST_INIT1 && (rx_fc1 || rx_fc2)) begin
        fi1 <= fi1 | fi1_hit;
        fc_hdr_lim_o[rx_sel*HDR_FC_W +: HDR_FC_W]    <= dllp_rx_hdr_fc_i;
        fc_data_lim_o[rx_sel*DATA_FC_W +: DATA_FC_W] <= dllp_rx_data_fc_i;
      end
      if (state == ST_ACTIVE && rx_upd) begin
        fc_hdr_lim_o[rx_sel*HDR_FC_W +: HDR_FC_W]    <= dllp_rx_hdr_fc_i;
        fc_data_lim_o[rx_sel*DATA_FC_W +: DATA_FC_W] <= dllp_rx_data_fc_i;
      end
      if (state == ST_INIT2 && (rx_fc2 || rx_upd))
        fi2 <= 1'b1;

      if (state_nxt != state && state_nxt != ST_ACTIVE) begin
        dllp_tx_valid_o   <= 1'b1;
        dllp_tx_type_o    <= {cls_entry, 2'b00, 4'h0};
        dllp_tx_hdr_fc_o  <= HDR_FC_W'(ADV_HDR);
        dllp_tx_data_fc_o <= DATA_FC_W'(ADV_DATA);
        tx_idx            <= '0;
        timer             <= '0;
      end else if (state_nxt == ST_ACTIVE) begin
        dllp_tx_valid_o <= 1'b0;
        timer           <= '0;
      end else if (tx_accept) begin
        dllp_tx_valid_o <= 1'b0;
        timer           <= TMR_W'(RESEND_CYC - 1);
        tx_idx          <= (tx_idx == 2'd2) ? 2'd0 : tx_idx + 2'd1;
        if (tx_idx == 2'd2)
          cpl_sent <= 1'b1;
      end else if (!dllp_tx_valid_o && timer == TMR_W'(1)) begin
        dllp_tx_valid_o <= 1'b1;
        dllp_tx_type_o  <= {cls_cur, tx_idx, 4'h0};
        timer           <= '0;
      end else if (timer != '0) begin
        timer <= timer - TMR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dll_dlcmsm_fc.sv
// tb_dll_dlcmsm_fc: directed-vector bench for the flow-control init state machine.
module tb_dll_dlcmsm_fc;

  logic        clk = 1'b0;
  logic        rst;
  logic        link_up_i;
  logic        dllp_rx_valid_i;
  logic [7:0]  dllp_rx_type_i;
  logic [7:0]  dllp_rx_hdr_fc_i;
  logic [11:0] dllp_rx_data_fc_i;
  logic        dllp_tx_valid_o;
  logic        dllp_tx_ready_i;
  logic [7:0]  dllp_tx_type_o;
  logic [7:0]  dllp_tx_hdr_fc_o;
  logic [11:0] dllp_tx_data_fc_o;
  logic [1:0]  state_o;
  logic        dl_up_o;
  logic [23:0] fc_hdr_lim_o;
  logic [35:0] fc_data_lim_o;

  int vecCount  = 0;
  int missCount = 0;

  dll_dlcmsm_fc dut (
    .clk               (clk),
    .rst               (rst),
    .link_up_i         (link_up_i),
    .dllp_rx_valid_i   (dllp_rx_valid_i),
    .dllp_rx_type_i    (dllp_rx_type_i),
    .dllp_rx_hdr_fc_i  (dllp_rx_hdr_fc_i),
    .dllp_rx_data_fc_i (dllp_rx_data_fc_i),
    .dllp_tx_valid_o   (dllp_tx_valid_o),
    .dllp_tx_ready_i   (dllp_tx_ready_i),
    .dllp_tx_type_o    (dllp_tx_type_o),
    .dllp_tx_hdr_fc_o  (dllp_tx_hdr_fc_o),
    .dllp_tx_data_fc_o (dllp_tx_data_fc_o),
    .state_o           (state_o),
    .dl_up_o           (dl_up_o),
    .fc_hdr_lim_o      (fc_hdr_lim_o),
    .fc_data_lim_o     (fc_data_lim_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] t, input logic [7:0] h, input logic [11:0] d);
    dllp_rx_valid_i   = v;
    dllp_rx_type_i    = t;
    dllp_rx_hdr_fc_i  = h;
    dllp_rx_data_fc_i = d;
  endtask

  initial begin
    rst             = 1'b1;
    link_up_i       = 1'b0;
    dllp_tx_ready_i = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 12'h000);
    #1;
    checkOutput("rst_state", 64'(state_o), 64'd0);
    checkOutput("rst_valid", 64'(dllp_tx_valid_o), 64'd0);
    checkOutput("rst_hdrlim", 64'(fc_hdr_lim_o), 64'd0);
    tick(2);
    rst = 1'b0;
    tick();
    checkOutput("idle_state", 64'(state_o), 64'd0);

    // First INIT1 pass, ready always high, nothing received.
    link_up_i = 1'b1;
    tick();
    checkOutput("init1_state", 64'(state_o), 64'd1);
    checkOutput("fc1_p_valid", 64'(dllp_tx_valid_o), 64'd1);
    checkOutput("fc1_p_type", 64'(dllp_tx_type_o), 64'h40);
    checkOutput("adv_hdr", 64'(dllp_tx_hdr_fc_o), 64'd32);
    checkOutput("adv_data", 64'(dllp_tx_data_fc_o), 64'd256);
    tick(33);
    checkOutput("gap_valid", 64'(dllp_tx_valid_o), 64'd0);
    tick();
    checkOutput("fc1_np_valid", 64'(dllp_tx_valid_o), 64'd1);
    checkOutput("fc1_np_type", 64'(dllp_tx_type_o), 64'h50);
    tick(34);
    checkOutput("fc1_cpl_type", 64'(dllp_tx_type_o), 64'h60);
    tick(34);
    checkOutput("fc1_wrap_type", 64'(dllp_tx_type_o), 64'h40);
    checkOutput("fc1_wrap_valid", 64'(dllp_tx_valid_o), 64'd1);
    checkOutput("still_init1", 64'(state_o), 64'd1);

    // Transmitter stalls: request must be held unchanged.
    dllp_tx_ready_i = 1'b0;
    tick(50);
    checkOutput("stall_valid", 64'(dllp_tx_valid_o), 64'd1);
    checkOutput("stall_type", 64'(dllp_tx_type_o), 64'h40);

    // Receive InitFC1 P/NP/CPL; P acceptance coincides with P receipt.
    dllp_tx_ready_i = 1'b1;
    applyStimulus(1'b1, 8'h40, 8'd10, 12'd100);
    tick();
    checkOutput("accept_rx_valid", 64'(dllp_tx_valid_o), 64'd0);
    applyStimulus(1'b1, 8'h50, 8'd20, 12'd200);
    tick();
    checkOutput("two_flags_state", 64'(state_o), 64'd1);
    applyStimulus(1'b1, 8'h65, 8'd30, 12'd300);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 12'h000);
    checkOutput("init2_state", 64'(state_o), 64'd2);
    checkOutput("hdr_lims", 64'(fc_hdr_lim_o), 64'({8'd30, 8'd20, 8'd10}));
    checkOutput("data_lims", 64'(fc_data_lim_o), 64'({12'd300, 12'd200, 12'd100}));
    checkOutput("fc2_p_type", 64'(dllp_tx_type_o), 64'hC0);
    checkOutput("fc2_p_valid", 64'(dllp_tx_valid_o), 64'd1);

    // INIT2: InitFC1 must not touch limits; round robin continues with 0xD0.
    applyStimulus(1'b1, 8'h40, 8'd99, 12'd999);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 12'h000);
    checkOutput("init2_fc1_ignored", 64'(fc_hdr_lim_o), 64'({8'd30, 8'd20, 8'd10}));
    checkOutput("init2_hold", 64'(state_o), 64'd2);
    tick(33);
    checkOutput("fc2_np_type", 64'(dllp_tx_type_o), 64'hD0);
    checkOutput("fc2_np_valid", 64'(dllp_tx_valid_o), 64'd1);

    // UpdateFC in INIT2 completes init.
    applyStimulus(1'b1, 8'h80, 8'd5, 12'd0);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 12'h000);
    checkOutput("active_state", 64'(state_o), 64'd3);
    checkOutput("active_dlup", 64'(dl_up_o), 64'd1);
    checkOutput("active_valid", 64'(dllp_tx_valid_o), 64'd0);
    checkOutput("active_lims", 64'(fc_hdr_lim_o), 64'({8'd30, 8'd20, 8'd10}));

    // ACTIVE: UpdateFC NP reloads, InitFC2 and unknown types do not.
    applyStimulus(1'b1, 8'h93, 8'd7, 12'd9);
    tick();
    applyStimulus(1'b1, 8'hC0, 8'd50, 12'd50);
    tick();
    applyStimulus(1'b1, 8'h20, 8'd60, 12'd60);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 12'h000);
    checkOutput("upd_np_hdr", 64'(fc_hdr_lim_o), 64'({8'd30, 8'd7, 8'd10}));
    checkOutput("upd_np_data", 64'(fc_data_lim_o), 64'({12'd300, 12'd9, 12'd100}));
    checkOutput("active_quiet", 64'(dllp_tx_valid_o), 64'd0);

    // Link down together with a valid UpdateFC: link-down wins.
    link_up_i = 1'b0;
    applyStimulus(1'b1, 8'hA0, 8'd1, 12'd1);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 12'h000);
    checkOutput("down_state", 64'(state_o), 64'd0);
    checkOutput("down_dlup", 64'(dl_up_o), 64'd0);
    checkOutput("down_hdrlim", 64'(fc_hdr_lim_o), 64'd0);
    checkOutput("down_datalim", 64'(fc_data_lim_o), 64'd0);
    tick();
    link_up_i = 1'b1;
    tick();
    checkOutput("relink_state", 64'(state_o), 64'd1);
    checkOutput("relink_type", 64'(dllp_tx_type_o), 64'h40);
    checkOutput("relink_valid", 64'(dllp_tx_valid_o), 64'd1);

    // All flags set before any CPL request: INIT2 waits for CPL acceptance.
    applyStimulus(1'b1, 8'h40, 8'd1, 12'd2);
    tick();
    applyStimulus(1'b1, 8'h50, 8'd3, 12'd4);
    tick();
    applyStimulus(1'b1, 8'h60, 8'd5, 12'd6);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 12'h000);
    checkOutput("wait_cpl_state", 64'(state_o), 64'd1);
    tick(65);
    checkOutput("cpl_req_type", 64'(dllp_tx_type_o), 64'h60);
    checkOutput("cpl_req_state", 64'(state_o), 64'd1);
    tick();
    checkOutput("after_cpl_state", 64'(state_o), 64'd2);
    checkOutput("after_cpl_type", 64'(dllp_tx_type_o), 64'hC0);

    // Asynchronous reset mid-INIT2.
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_state", 64'(state_o), 64'd0);
    checkOutput("async_valid", 64'(dllp_tx_valid_o), 64'd0);
    checkOutput("async_type", 64'(dllp_tx_type_o), 64'd0);
    checkOutput("async_txhdr", 64'(dllp_tx_hdr_fc_o), 64'd0);
    checkOutput("async_hdrlim", 64'(fc_hdr_lim_o), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("post_rst_state", 64'(state_o), 64'd1);
    checkOutput("post_rst_type", 64'(dllp_tx_type_o), 64'h40);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
